// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus seen by the UART transmitter window.
// we/addr/d_in driven by the CPU (master), d_out answered by the block (slave).
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [31:0] d_out;

    modport master (
        output we,
        output addr,
        output d_in,
        input  d_out
    );

    modport slave (
        input  we,
        input  addr,
        input  d_in,
        output d_out
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Ports: clk, reset (async, active high), bus (slave: we/addr/d_in/d_out), tx.
module mmio_uart_tx #(
    parameter logic [31:0] BASE       = 32'h0000_0100,
    parameter logic [15:0] DIV_RESET  = 16'd868,
    parameter int          DEPTH_LOG2 = 2
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           tx
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t state_nx;

    // Address decode
    logic       hit;
    logic [1:0] off;
    logic       wr_data;
    logic       wr_status;
    logic       wr_div;

    assign hit       = (bus.addr[31:4] == BASE[31:4]);
    assign off       = bus.addr[3:2];
    assign wr_data   = bus.we && hit && (off == 2'd0);
    assign wr_status = bus.we && hit && (off == 2'd1);
    assign wr_div    = bus.we && hit && (off == 2'd2);

    // FIFO
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  overflow;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // A pop in the same edge frees a slot, so a push into a full FIFO survives.
    assign push  = wr_data && (!full || pop);
    assign drop  = wr_data && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.d_in[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Control registers
    logic [15:0] div;
    logic [15:0] eff_div;

    assign eff_div = (div == 16'd0) ? 16'd1 : div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            div      <= DIV_RESET;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (wr_status) begin
                overflow <= 1'b0;
            end
            if (wr_div) begin
                div <= bus.d_in[15:0];
            end
        end
    end

    // Shift engine
    logic [7:0]  shift;
    logic [7:0]  shift_nx;
    logic [15:0] period;
    logic [15:0] period_nx;
    logic [15:0] cyc;
    logic [15:0] cyc_nx;
    logic [2:0]  bitcnt;
    logic [2:0]  bitcnt_nx;
    logic        tx_nx;
    logic        last;
    logic        start_frame;
    logic        busy;

    assign last = (cyc == period - 16'd1);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        shift_nx    = shift;
        period_nx   = period;
        cyc_nx      = cyc;
        bitcnt_nx   = bitcnt;
        tx_nx       = tx;
        start_frame = 1'b0;
        unique case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (!empty) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (last) begin
                    cyc_nx   = '0;
                    tx_nx    = shift[0];
                    state_nx = DATA;
                end else begin
                    cyc_nx = cyc + 16'd1;
                end
            end
            DATA: begin
                if (last) begin
                    cyc_nx = '0;
                    if (bitcnt == 3'd7) begin
                        bitcnt_nx = '0;
                        tx_nx     = 1'b1;
                        state_nx  = STOP;
                    end else begin
                        shift_nx  = {1'b0, shift[7:1]};
                        tx_nx     = shift[1];
                        bitcnt_nx = bitcnt + 3'd1;
                    end
                end else begin
                    cyc_nx = cyc + 16'd1;
                end
            end
            STOP: begin
                if (last) begin
                    cyc_nx = '0;
                    if (!empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cyc_nx = cyc + 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
            end
        endcase
        // Back-to-back frames reuse the same load path as a start from idle.
        if (start_frame) begin
            shift_nx  = mem[rd_ptr];
            period_nx = eff_div;
            cyc_nx    = '0;
            bitcnt_nx = '0;
            tx_nx     = 1'b0;
            state_nx  = START;
        end
    end

    assign pop = start_frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift  <= '0;
            period <= 16'd1;
            cyc    <= '0;
            bitcnt <= '0;
            tx     <= 1'b1;
        end else begin
            shift  <= shift_nx;
            period <= period_nx;
            cyc    <= cyc_nx;
            bitcnt <= bitcnt_nx;
            tx     <= tx_nx;
        end
    end

    // Load data: pre-edge register values, zero outside the window.
    always_comb begin
        bus.d_out = '0;
        if (hit) begin
            unique case (off)
                2'd1:    bus.d_out = {28'b0, overflow, busy, full, empty};
                2'd2:    bus.d_out = {16'b0, div};
                default: bus.d_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx.
// Expected line levels come from an 8N1 frame model over a byte queue.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic clk;
    logic reset;
    logic tx;
    int   total;
    int   bad;
    logic [7:0] exp_q [$];

    mmio_uart_tx_if bus ();

    mmio_uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    // Level of the line i cycles after the first frame start, period p.
    function automatic logic exp_line(input int i, input int p);
        int f;
        int k;
        logic [7:0] b;
        f = i / (10 * p);
        k = (i % (10 * p)) / p;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        b = exp_q[f];
        return b[k-1];
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.d_in = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] v);
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        v = bus.d_out;
    endtask

    // Receives frames by mid-bit sampling until the line stays idle.
    task automatic rx(input int p, output logic [7:0] got [$]);
        logic [7:0] b;
        logic found;
        got = {};
        for (int f = 0; f < 16; f++) begin
            found = 1'b0;
            for (int w = 0; w < 12 * p + 20 && !found; w++) begin
                @(posedge clk);
                #1;
                if (tx === 1'b0) found = 1'b1;
            end
            if (!found) break;
            repeat (p / 2) begin
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < 8; k++) begin
                repeat (p) begin
                    @(posedge clk);
                    #1;
                end
                b[k] = tx;
            end
            repeat (p) begin
                @(posedge clk);
                #1;
            end
            total++;
            if (tx !== 1'b1) begin
                bad++;
                $display("FAIL rx_stop frame %0d: got %b want 1", f, tx);
            end
            got.push_back(b);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        #3;
        total++;
        if (tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        load(A_STAT, v);
        total++;
        if (v !== 32'h1) begin
            bad++;
            $display("FAIL reset_status: got %h want 1", v);
        end
        load(A_DIV, v);
        total++;
        if (v !== 32'd868) begin
            bad++;
            $display("FAIL reset_div: got %0d want 868", v);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_frame;
        logic [7:0] r;
        logic [31:0] v;
        r = 8'($urandom);
        store(A_DIV, 32'd4);
        exp_q = {8'h55, r};
        fork
            begin
                store(A_DATA, 32'h55);
                store(A_DATA, {24'hABCDEF, r});
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 80; i++) begin
                    @(posedge clk);
                    #2;
                    bus.addr = A_STAT;
                    #1;
                    total++;
                    if (tx !== exp_line(i, 4)) begin
                        bad++;
                        $display("FAIL frame_tx cyc %0d: got %b want %b",
                                 i, tx, exp_line(i, 4));
                    end
                    total++;
                    if (bus.d_out[2] !== 1'b1) begin
                        bad++;
                        $display("FAIL frame_busy cyc %0d: got %b want 1",
                                 i, bus.d_out[2]);
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        load(A_STAT, v);
        total++;
        if (v !== 32'h1 || tx !== 1'b1) begin
            bad++;
            $display("FAIL frame_end: status %h tx %b want 1 1", v, tx);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        store(A_DIV, 32'd2);
        exp_q = {8'hA3, 8'h0F, 8'hFF, 8'h00, 8'h81};
        fork
            begin
                for (int k = 0; k < 5; k++) store(A_DATA, {24'h0, exp_q[k]});
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk);
                    #1;
                    total++;
                    if (tx !== exp_line(i, 2)) begin
                        bad++;
                        $display("FAIL b2b_tx cyc %0d: got %b want %b",
                                 i, tx, exp_line(i, 2));
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        load(A_STAT, v);
        total++;
        if (v !== 32'h1) begin
            bad++;
            $display("FAIL b2b_status: got %h want 1", v);
        end
    endtask

    task automatic test_overflow;
        logic [7:0]  bytes [6];
        logic [7:0]  got [$];
        logic [31:0] v;
        for (int k = 0; k < 6; k++) bytes[k] = 8'($urandom);
        store(A_DIV, 32'd8);
        fork
            begin
                for (int k = 0; k < 6; k++) store(A_DATA, {24'h0, bytes[k]});
                load(A_STAT, v);
                total++;
                if (v !== 32'hE) begin
                    bad++;
                    $display("FAIL ovf_status: got %h want e", v);
                end
                store(A_STAT, 32'h0);
                load(A_STAT, v);
                total++;
                if (v !== 32'h6) begin
                    bad++;
                    $display("FAIL ovf_clear: got %h want 6", v);
                end
            end
            rx(8, got);
        join
        total++;
        if (got.size() !== 5) begin
            bad++;
            $display("FAIL ovf_count: got %0d want 5", got.size());
        end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            total++;
            if (got[k] !== bytes[k]) begin
                bad++;
                $display("FAIL ovf_byte %0d: got %h want %h",
                         k, got[k], bytes[k]);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [7:0]  r;
        logic [31:0] v;
        int lows;
        @(negedge clk);
        bus.we   = 1'b1;
        bus.addr = A_DIV;
        bus.d_in = 32'h0;
        #1;
        total++;
        if (bus.d_out !== 32'd8) begin
            bad++;
            $display("FAIL div_preedge: got %0d want 8", bus.d_out);
        end
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        load(A_DIV, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL div_zero_read: got %h want 0", v);
        end
        r = 8'($urandom);
        exp_q = {r};
        fork
            store(A_DATA, {24'h0, r});
            begin
                @(posedge clk);
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk);
                    #1;
                    total++;
                    if (tx !== exp_line(i, 1)) begin
                        bad++;
                        $display("FAIL div0_tx cyc %0d: got %b want %b",
                                 i, tx, exp_line(i, 1));
                    end
                end
            end
        join
        store(A_RSV, 32'hFFFF_FFFF);
        load(A_RSV, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL rsv_read: got %h want 0", v);
        end
        store(32'h0000_0208, 32'd5);
        load(32'h0000_0208, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL outside_read: got %h want 0", v);
        end
        load(A_DIV, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL outside_div: got %h want 0", v);
        end
        store(32'h0000_0200, 32'h0000_0000);
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        load(A_STAT, v);
        total++;
        if (v !== 32'h1 || lows !== 0) begin
            bad++;
            $display("FAIL outside_push: status %h lows %0d want 1 0", v, lows);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] v;
        int lows;
        store(A_DIV, 32'd4);
        for (int k = 0; k < 3; k++) store(A_DATA, 32'($urandom_range(0, 254)));
        repeat (12) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1) begin
            bad++;
            $display("FAIL rst_tx: got %b want 1", tx);
        end
        load(A_STAT, v);
        total++;
        if (v !== 32'h1) begin
            bad++;
            $display("FAIL rst_status: got %h want 1", v);
        end
        load(A_DIV, v);
        total++;
        if (v !== 32'd868) begin
            bad++;
            $display("FAIL rst_div: got %0d want 868", v);
        end
        @(negedge clk);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL rst_flush: got %0d low cycles want 0", lows);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h0;
        bus.d_in = 32'h0;
        test_reset;
        test_frame;
        test_back_to_back;
        test_overflow;
        test_div_zero;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
